// File: rtl/light_ctrl_multi.sv
// -----------------------------------------------------------------------------
// light_ctrl_multi
//
// N-channel front-panel light controller. Each channel takes a raw push-button,
// synchronises and debounces it, and classifies each press with a small FSM:
//   - short press (released before LONG_CYCLES) toggles the channel's light
//   - long press (held LONG_CYCLES) steps the channel's brightness level,
//     wrapping from LEVELS-1 back to 0, but only while the light is on
// Each lamp is driven by a PWM output whose duty follows the brightness level.
// power_on gates everything: when low all lights are forced off and no press
// is recognised. Brightness levels are retained across power loss.
//
// Ports
//   clk        in   1          system clock
//   reset      in   1          asynchronous active-high reset
//   power_on   in   1          global enable, 0 forces all lights off
//   btn        in   N_CH       raw asynchronous buttons, 1 = pressed
//   light_on   out  N_CH       registered on/off state per channel
//   level      out  N_CH*LW    brightness per channel, ch i at [i*LW +: LW]
//   pwm_out    out  N_CH       registered PWM lamp drive
//   short_evt  out  N_CH       1-cycle pulse per accepted short press
//   long_evt   out  N_CH       1-cycle pulse per accepted long press
// -----------------------------------------------------------------------------
module light_ctrl_multi #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 200,
    parameter int LEVELS          = 4,
    parameter int PWM_BITS        = 8,
    localparam int LW             = $clog2(LEVELS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 power_on,
    input  logic [N_CH-1:0]      btn,
    output logic [N_CH-1:0]      light_on,
    output logic [N_CH*LW-1:0]   level,
    output logic [N_CH-1:0]      pwm_out,
    output logic [N_CH-1:0]      short_evt,
    output logic [N_CH-1:0]      long_evt
);

    localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW     = $clog2(LONG_CYCLES + 1);
    localparam int DUTY_W = PWM_BITS + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESSED   = 2'd1,
        S_LONG_HELD = 2'd2
    } state_t;

    // Next brightness level, wrapping at the top.
    function automatic logic [LW-1:0] f_next_level(input logic [LW-1:0] lvl);
        if (lvl == LW'(LEVELS - 1)) begin
            return '0;
        end
        return lvl + LW'(1);
    endfunction

    // PWM threshold for a level. One bit wider than the counter so that the
    // top level yields 2^PWM_BITS and the lamp stays constantly on.
    function automatic logic [DUTY_W-1:0] f_duty(input logic [LW-1:0] lvl);
        int unsigned t;
        t = ((32'(lvl) + 32'd1) << PWM_BITS) / 32'(LEVELS);
        return DUTY_W'(t);
    endfunction

    // Shared free-running PWM counter; all lamps share one period and phase.
    logic [PWM_BITS-1:0] r_pwm_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic              r_sync1;
        logic              r_sync2;
        logic              r_stable;
        logic              r_stable_d;
        logic [DBW-1:0]    r_db_cnt;
        logic [HW-1:0]     r_hold_cnt;
        state_t            r_state;
        logic              r_light;
        logic [LW-1:0]     r_level;
        logic              r_short;
        logic              r_long;
        logic              r_pwm;
        logic              w_rise;
        logic              w_fall;
        logic [DUTY_W-1:0] w_duty;

        // Edges of the debounced level. r_stable_d keeps tracking while power
        // is off, so a button held across power return shows no rise and
        // must be released and pressed again.
        assign w_rise = r_stable & ~r_stable_d;
        assign w_fall = ~r_stable & r_stable_d;
        assign w_duty = f_duty(r_level);

        // Synchroniser and debouncer. The counter runs while the synced level
        // disagrees with the accepted level; any agreement restarts it, so
        // only a sustained change is accepted.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync1    <= 1'b0;
                r_sync2    <= 1'b0;
                r_stable   <= 1'b0;
                r_stable_d <= 1'b0;
                r_db_cnt   <= '0;
            end else begin
                r_sync1    <= btn[g];
                r_sync2    <= r_sync1;
                r_stable_d <= r_stable;
                if (r_sync2 == r_stable) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DBW'(DEBOUNCE_CYCLES)) begin
                    r_stable <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DBW'(1);
                end
            end
        end

        // Press classifier with registered light state and event pulses.
        // A release takes priority over reaching the long threshold.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state    <= S_IDLE;
                r_hold_cnt <= '0;
                r_light    <= 1'b0;
                r_level    <= LW'(LEVELS - 1);
                r_short    <= 1'b0;
                r_long     <= 1'b0;
            end else begin
                r_short <= 1'b0;
                r_long  <= 1'b0;
                if (!power_on) begin
                    r_state    <= S_IDLE;
                    r_hold_cnt <= '0;
                    r_light    <= 1'b0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_rise) begin
                                r_state    <= S_PRESSED;
                                r_hold_cnt <= '0;
                            end
                        end
                        S_PRESSED: begin
                            if (w_fall) begin
                                r_state <= S_IDLE;
                                r_short <= 1'b1;
                                r_light <= ~r_light;
                            end else if (r_hold_cnt == HW'(LONG_CYCLES - 1)) begin
                                r_state    <= S_LONG_HELD;
                                r_long     <= 1'b1;
                                r_hold_cnt <= r_hold_cnt + HW'(1);
                                if (r_light) begin
                                    r_level <= f_next_level(r_level);
                                end
                            end else begin
                                r_hold_cnt <= r_hold_cnt + HW'(1);
                            end
                        end
                        S_LONG_HELD: begin
                            // hold_cnt stays saturated at LONG_CYCLES here
                            if (w_fall) begin
                                r_state <= S_IDLE;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                        end
                    endcase
                end
            end
        end

        // Lamp drive, registered off the current light state and level.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_pwm <= 1'b0;
            end else begin
                r_pwm <= power_on & r_light & ({1'b0, r_pwm_cnt} < w_duty);
            end
        end

        assign light_on[g]          = r_light;
        assign level[g*LW +: LW]    = r_level;
        assign pwm_out[g]           = r_pwm;
        assign short_evt[g]         = r_short;
        assign long_evt[g]          = r_long;
    end

endmodule
